// File: rtl/rom_loader_if.sv
// Byte-stream and ROM write-port bundle for rom_loader.
// The master modport is the loader's view. The slave modport is the UART/ROM side.
interface rom_loader_if;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  modport master (
    input  rx_valid_i, rx_data_i, mem_data_i,
    output rx_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, mem_data_i,
    input  rx_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/rom_loader.sv
// Boot loader: parses a length/payload/checksum byte frame and writes little-endian words into the ROM.
// Define ROM_LOADER_VERIFY_EN to read back and compare every written word.
module rom_loader #(
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  rom_loader_if.master bus,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [1:0]   err_code_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_BYTE,
    S_WRITE,
`ifdef ROM_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_CSUM,
    S_DONE
  } state_e;

  localparam logic [1:0]  ErrLen    = 2'b01;
  localparam logic [1:0]  ErrSum    = 2'b10;
`ifdef ROM_LOADER_VERIFY_EN
  localparam logic [1:0]  ErrVerify = 2'b11;
`endif
  localparam logic [16:0] MaxWords  = 17'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        xfer;
  logic [15:0] lenRx;
  logic [15:0] idxInc;
  logic [31:0] wordIns;

  assign xfer   = bus.rx_valid_i & bus.rx_ready_o;
  assign lenRx  = {bus.rx_data_i, count_q[7:0]};
  assign idxInc = idx_q + 16'd1;

`ifndef ROM_LOADER_VERIFY_EN
  logic unusedMemData;
  assign unusedMemData = ^bus.mem_data_i;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    code_d  = code_q;
    wordIns = word_q;
    wordIns[{lane_q, 3'b000} +: 8] = bus.rx_data_i;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_HDR0;
          idx_d   = 16'd0;
          lane_d  = 2'd0;
          csum_d  = 8'd0;
          code_d  = 2'b00;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          count_d[7:0] = bus.rx_data_i;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          count_d = lenRx;
          if ({1'b0, lenRx} > MaxWords) begin
            code_d  = ErrLen;
            state_d = S_DONE;
          end else if (lenRx == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_BYTE;
          end
        end
      end
      // The write strobe is registered, so address and data are launched as the 4th byte lands.
      S_BYTE: begin
        if (xfer) begin
          word_d = wordIns;
          csum_d = csum_q + bus.rx_data_i;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = ROM_BASE + {14'd0, idx_q, 2'b00};
            data_d  = wordIns;
          end
        end
      end
      S_WRITE: begin
        idx_d = idxInc;
`ifdef ROM_LOADER_VERIFY_EN
        state_d = S_VERIFY;
`else
        state_d = (idxInc < count_q) ? S_BYTE : S_CSUM;
`endif
      end
`ifdef ROM_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (bus.mem_data_i != data_q) begin
          code_d  = ErrVerify;
          state_d = S_DONE;
        end else begin
          state_d = (idx_q < count_q) ? S_BYTE : S_CSUM;
        end
      end
`endif
      S_CSUM: begin
        if (xfer) begin
          if (bus.rx_data_i != csum_q) code_d = ErrSum;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_DONE) && (code_d != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= 16'd0;
      idx_q   <= 16'd0;
      lane_q  <= 2'd0;
      word_q  <= 32'd0;
      csum_q  <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus.rx_ready_o = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                          (state_q == S_BYTE) || (state_q == S_CSUM);
  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign err_code_o     = code_q;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: a frame-level model predicts ROM writes and the final status,
// and a write monitor checks every mem_we_o pulse against the expected-write queue.
module tb_rom_loader;
  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam int          MAX_WORDS = 4096;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       start_i = 1'b0;
  logic       busy_o, done_o, err_o;
  logic [1:0] err_code_o;

  rom_loader_if bus();

  logic [31:0] rom [0:4095];
  logic        forceBad = 1'b0;
  wr_t         expQ[$];
  logic [7:0]  payloadQ[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rom_loader #(
    .ROM_BASE (ROM_BASE),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .bus       (bus.master),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .err_code_o(err_code_o)
  );

  // ROM model with combinational read; forceBad makes word address 0x4 read back as zero.
  assign bus.mem_data_i = (forceBad && bus.mem_addr_o == 32'h4) ? 32'h0 : rom[bus.mem_addr_o[13:2]];

  always @(posedge clk) begin
    if (bus.mem_we_o) rom[bus.mem_addr_o[13:2]] <= bus.mem_data_o;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the next predicted write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_we_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected write: got addr %h data %h, expected no write",
                 bus.mem_addr_o, bus.mem_data_o);
      end else begin
        e = expQ.pop_front();
        checkOutput("write addr", bus.mem_addr_o, e.addr);
        checkOutput("write data", bus.mem_data_o, e.data);
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " busy_o"},     32'(busy_o), 32'd0);
    checkOutput({tag, " done_o"},     32'(done_o), 32'd0);
    checkOutput({tag, " err_o"},      32'(err_o), 32'd0);
    checkOutput({tag, " err_code_o"}, 32'(err_code_o), 32'd0);
    checkOutput({tag, " rx_ready_o"}, 32'(bus.rx_ready_o), 32'd0);
    checkOutput({tag, " mem_we_o"},   32'(bus.mem_we_o), 32'd0);
    checkOutput({tag, " mem_addr_o"}, bus.mem_addr_o, 32'd0);
    checkOutput({tag, " mem_data_o"}, bus.mem_data_o, 32'd0);
  endtask

  task automatic resetDut;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Entered and left at a negedge. mode 0: back-to-back, 1: one idle cycle per byte, 2: random gaps plus stray start pulses.
  task automatic sendByte(input logic [7:0] b, input int mode, output bit ok);
    int idle;
    int guard;
    ok    = 1'b1;
    guard = 0;
    idle  = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
    repeat (idle) @(negedge clk);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    if (mode == 2 && $urandom_range(0, 7) == 0) start_i = 1'b1;
    while (bus.rx_ready_o !== 1'b1) begin
      @(negedge clk);
      start_i = 1'b0;
      guard++;
      if (guard > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL rx_ready timeout: got 0, expected 1 within 50 cycles");
        ok = 1'b0;
        break;
      end
    end
    if (ok) @(negedge clk);
    bus.rx_valid_i = 1'b0;
    start_i        = 1'b0;
    bus.rx_data_i  = 8'($urandom);
  endtask

  task automatic startLoad;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("start busy_o",     32'(busy_o), 32'd1);
    checkOutput("start done_o",     32'(done_o), 32'd0);
    checkOutput("start err_o",      32'(err_o), 32'd0);
    checkOutput("start err_code_o", 32'(err_code_o), 32'd0);
    checkOutput("start rx_ready_o", 32'(bus.rx_ready_o), 32'd1);
  endtask

  // Frame-level reference model: derives the writes, consumed bytes and final error code, then drives the frame.
  task automatic applyStimulus(input logic [15:0] n, input logic [7:0] csum, input int mode);
    logic [7:0]  sendQ[$];
    int          code;
    logic [7:0]  sum;
    logic [31:0] w;
    logic [31:0] a;
    bit          ok;
    int          waitCycles;
    code = 0;
    sum  = 8'd0;
    sendQ.push_back(n[7:0]);
    sendQ.push_back(n[15:8]);
    if (int'(n) > MAX_WORDS) begin
      code = 1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        w = {payloadQ[4*i+3], payloadQ[4*i+2], payloadQ[4*i+1], payloadQ[4*i]};
        a = ROM_BASE + 32'(4 * i);
        expQ.push_back('{a, w});
        for (int k = 0; k < 4; k++) begin
          sendQ.push_back(payloadQ[4*i+k]);
          sum = sum + payloadQ[4*i+k];
        end
`ifdef ROM_LOADER_VERIFY_EN
        if (forceBad && a == 32'h4 && w != 32'h0) begin
          code = 3;
          break;
        end
`endif
      end
      if (code == 0) begin
        sendQ.push_back(csum);
        if (csum != sum) code = 2;
      end
    end

    startLoad();
    ok = 1'b1;
    foreach (sendQ[j]) begin
      if (ok) sendByte(sendQ[j], mode, ok);
    end
    if (code == 3) begin
      waitCycles = 0;
      while (done_o !== 1'b1 && waitCycles < 10) begin
        @(negedge clk);
        waitCycles++;
      end
    end

    checkOutput("end done_o",     32'(done_o), 32'd1);
    checkOutput("end busy_o",     32'(busy_o), 32'd0);
    checkOutput("end err_o",      32'(err_o), 32'(code != 0));
    checkOutput("end err_code_o", 32'(err_code_o), 32'(code));
    checkOutput("end rx_ready_o", 32'(bus.rx_ready_o), 32'd0);
    checkOutput("end mem_we_o",   32'(bus.mem_we_o), 32'd0);
    checkOutput("pending writes", 32'(expQ.size()), 32'd0);
    if (!ok || expQ.size() != 0) begin
      expQ.delete();
      resetDut();
    end
  endtask

  initial begin
    logic [15:0] n;
    logic [7:0]  s;
    bit          ok;

    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // This payload sums to 0x4C mod 256.
    payloadQ = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(16'd2, 8'h4C, 0);
    applyStimulus(16'd2, 8'h2F, 0);

    payloadQ.delete();
    applyStimulus(16'h1001, 8'h00, 0);

    payloadQ = '{8'h78, 8'h56, 8'h34, 8'h12};
    applyStimulus(16'd1, 8'h14, 1);

    payloadQ.delete();
    applyStimulus(16'd0, 8'h00, 0);
    applyStimulus(16'd0, 8'h05, 0);

    startLoad();
    sendByte(8'h02, 0, ok);
    sendByte(8'h00, 0, ok);
    sendByte(8'h78, 0, ok);
    sendByte(8'h56, 0, ok);
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("midframe reset");
    rst = 1'b1;
    @(negedge clk);
    payloadQ = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(16'd2, 8'h4C, 2);

    payloadQ.delete();
    s = 8'd0;
    for (int i = 0; i < 4 * MAX_WORDS; i++) begin
      payloadQ.push_back(8'($urandom));
      s = s + payloadQ[i];
    end
    applyStimulus(16'(MAX_WORDS), s, 0);

    for (int f = 0; f < 20; f++) begin
      payloadQ.delete();
      if ($urandom_range(0, 9) == 0) n = 16'($urandom_range(MAX_WORDS + 1, 65535));
      else n = 16'($urandom_range(0, 6));
      s = 8'd0;
      if (int'(n) <= MAX_WORDS) begin
        for (int i = 0; i < 4 * int'(n); i++) begin
          payloadQ.push_back(8'($urandom));
          s = s + payloadQ[i];
        end
      end
      if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
      applyStimulus(n, s, 2);
    end

`ifdef ROM_LOADER_VERIFY_EN
    forceBad = 1'b1;
    payloadQ = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(16'd2, 8'h4C, 0);
    forceBad = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
